// File: rtl/router_out_arb_if.sv
// Flit handshake bundle between the input ports, the output arbiter and the output link.
// "slave" is the arbiter's side; "master" is the side that feeds flits and drains the link.
interface router_out_arb_if #(
    parameter int FLIT_W = 18,
    parameter int NUM_IN = 5
);
    logic [NUM_IN*FLIT_W-1:0] in_flit;
    logic [NUM_IN-1:0]        in_valid;
    logic [NUM_IN-1:0]        in_ready;
    logic [FLIT_W-1:0]        out_flit;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        output in_flit, in_valid, out_ready,
        input  in_ready, out_flit, out_valid
    );

    modport slave (
        input  in_flit, in_valid, out_ready,
        output in_ready, out_flit, out_valid
    );
endinterface

// File: rtl/router_out_arb.sv
// Wormhole output-port arbiter: round-robin grant on head/single flits, with the port
// locked to its owner until the tail (or single) flit has been transferred.
module router_out_arb #(
    parameter int FLIT_W = 18,
    parameter int NUM_IN = 5
) (
    input  logic              clk,
    input  logic              rst,
    router_out_arb_if.slave   bus,
    output logic [NUM_IN-1:0] grant,
    output logic              busy,
    output logic [15:0]       pkt_cnt
);

    localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [15:0]        pkt_cnt_q, pkt_cnt_d;

    logic [FLIT_W-1:0]  flit_arr [NUM_IN];
    logic [NUM_IN-1:0]  req;
    logic [FLIT_W-1:0]  owner_flit;
    logic               owner_valid;
    logic               xfer;
    logic               found;
    logic [IDX_W-1:0]   pick;

    // Type bit FLIT_W-2 is set exactly for head (01) and single (11) flits.
    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_port
            assign flit_arr[gi] = bus.in_flit[gi*FLIT_W +: FLIT_W];
            assign req[gi]      = bus.in_valid[gi] & flit_arr[gi][FLIT_W-2];
        end
    endgenerate

    assign owner_flit  = flit_arr[owner_q];
    assign owner_valid = bus.in_valid[owner_q];
    assign xfer        = (state_q == ST_LOCKED) && owner_valid && bus.out_ready;

    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        pick  = '0;
        for (int k = 1; k <= NUM_IN; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_IN) idx = idx - NUM_IN;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = IDX_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= '0;
            ptr_q     <= IDX_W'(NUM_IN - 1);
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        pkt_cnt_d = pkt_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d = ST_LOCKED;
                    owner_d = pick;
                end
            end
            ST_LOCKED: begin
                // Only the top type bit matters: tail (10) and single (11) close the packet.
                if (xfer && owner_flit[FLIT_W-1]) begin
                    state_d   = ST_IDLE;
                    ptr_d     = owner_q;
                    pkt_cnt_d = pkt_cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        grant         = '0;
        busy          = 1'b0;
        bus.out_valid = 1'b0;
        bus.in_ready  = '0;
        bus.out_flit  = owner_flit;
        if (state_q == ST_LOCKED) begin
            grant[owner_q]        = 1'b1;
            busy                  = 1'b1;
            bus.out_valid         = owner_valid;
            bus.in_ready[owner_q] = bus.out_ready;
        end
    end

    assign pkt_cnt = pkt_cnt_q;

endmodule

// File: tb/tb_router_out_arb.sv
// Bench for router_out_arb: directed vector tables for the corner cases, then random
// traffic checked cycle by cycle against a packet-level reference model.
module tb_router_out_arb;

    localparam int FW = 18;
    localparam int NI = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    router_out_arb_if #(.FLIT_W(FW), .NUM_IN(NI)) bus ();
    logic [NI-1:0] grant;
    logic          busy;
    logic [15:0]   pkt_cnt;

    router_out_arb #(.FLIT_W(FW), .NUM_IN(NI)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .grant   (grant),
        .busy    (busy),
        .pkt_cnt (pkt_cnt)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic             rst_n;
        logic [NI*FW-1:0] flits;
        logic [NI-1:0]    vld;
        logic             ordy;
        logic [NI-1:0]    e_grant;
        logic             e_ov;
        logic [FW-1:0]    e_flit;
        logic [NI-1:0]    e_rdy;
        logic [15:0]      e_cnt;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [NI*FW-1:0] f, input logic [NI-1:0] v,
                                input logic o, input logic [NI-1:0] g, input logic ov,
                                input logic [FW-1:0] ef, input logic [NI-1:0] er, input logic [15:0] c);
        vec_t t;
        t.rst_n = r; t.flits = f; t.vld = v; t.ordy = o;
        t.e_grant = g; t.e_ov = ov; t.e_flit = ef; t.e_rdy = er; t.e_cnt = c;
        return t;
    endfunction

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        rst           = v.rst_n;
        bus.in_flit   = v.flits;
        bus.in_valid  = v.vld;
        bus.out_ready = v.ordy;
        #1;
        check({tag, " grant"},     32'(grant),         32'(v.e_grant));
        check({tag, " busy"},      32'(busy),          32'(|v.e_grant));
        check({tag, " out_valid"}, 32'(bus.out_valid), 32'(v.e_ov));
        check({tag, " in_ready"},  32'(bus.in_ready),  32'(v.e_rdy));
        check({tag, " pkt_cnt"},   32'(pkt_cnt),       32'(v.e_cnt));
        if (v.e_ov) check({tag, " out_flit"}, 32'(bus.out_flit), 32'(v.e_flit));
        $display("vec %s: rst=%b vld=%b ordy=%b -> grant=%b ov=%b flit=%h rdy=%b cnt=%0d",
                 tag, v.rst_n, v.vld, v.ordy, grant, bus.out_valid, bus.out_flit, bus.in_ready, pkt_cnt);
    endtask

    initial begin
        vec_t tbl[$];
        logic [NI*FW-1:0] fa, fb, f;
        logic [FW-1:0] h, b1, b2, t, x, xt, p1h, p1b, p1h2, p4h;
        logic [FW-1:0] pf [NI];
        int left [NI];
        int owner, ptr, cnt;

        bus.in_flit = '0; bus.in_valid = '0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);

        // Single flit, ignored body flit in IDLE, then round-robin over five single flits.
        fa = {18'h0a349, 18'h3a349, 18'h0, 18'h0, 18'h0};
        fb = {18'h35555, 18'h3a349, 18'h33333, 18'h32222, 18'h31111};
        tbl.push_back(mk(0, fa, 5'b10000, 1, 5'b00000, 0, 18'h0,     5'b00000, 0));
        tbl.push_back(mk(1, fa, 5'b10000, 1, 5'b00000, 0, 18'h0,     5'b00000, 0));
        tbl.push_back(mk(1, fa, 5'b10000, 1, 5'b00000, 0, 18'h0,     5'b00000, 0));
        tbl.push_back(mk(1, fa, 5'b01000, 1, 5'b00000, 0, 18'h0,     5'b00000, 0));
        tbl.push_back(mk(1, fa, 5'b01000, 1, 5'b01000, 1, 18'h3a349, 5'b01000, 0));
        tbl.push_back(mk(1, fa, 5'b00000, 1, 5'b00000, 0, 18'h0,     5'b00000, 1));
        tbl.push_back(mk(0, fb, 5'b11111, 1, 5'b00000, 0, 18'h0,     5'b00000, 0));
        tbl.push_back(mk(1, fb, 5'b11111, 1, 5'b00000, 0, 18'h0,     5'b00000, 0));
        for (int i = 0; i < 6; i++) begin
            int p;
            p = i % NI;
            f = fb;
            tbl.push_back(mk(1, fb, 5'b11111, 1, 5'(1 << p), 1, f[p*FW +: FW], 5'(1 << p), 16'(i)));
            tbl.push_back(mk(1, fb, 5'b11111, 1, 5'b00000, 0, 18'h0, 5'b00000, 16'(i + 1)));
        end
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("tbl%0d", i));

        // Wormhole with a head-type mid-packet flit, 3-cycle backpressure, then owner stall.
        h = 18'h10001; b1 = 18'h10002; b2 = 18'h00003; t = 18'h20004; x = 18'h10aaa; xt = 18'h20bbb;
        apply(mk(0, {18'h0, 18'h0, x, 18'h0, h},  5'b00101, 1, 5'b00000, 0, 18'h0, 5'b00000, 0), "worm_rst");
        apply(mk(1, {18'h0, 18'h0, x, 18'h0, h},  5'b00101, 1, 5'b00000, 0, 18'h0, 5'b00000, 0), "worm_arb");
        apply(mk(1, {18'h0, 18'h0, x, 18'h0, h},  5'b00101, 1, 5'b00001, 1, h,     5'b00001, 0), "worm_head");
        apply(mk(1, {18'h0, 18'h0, x, 18'h0, b1}, 5'b00101, 1, 5'b00001, 1, b1,    5'b00001, 0), "worm_b1");
        for (int i = 0; i < 3; i++)
            apply(mk(1, {18'h0, 18'h0, x, 18'h0, b2}, 5'b00101, 0, 5'b00001, 1, b2, 5'b00000, 0),
                  $sformatf("worm_stall%0d", i));
        apply(mk(1, {18'h0, 18'h0, x, 18'h0, b2}, 5'b00101, 1, 5'b00001, 1, b2,    5'b00001, 0), "worm_b2");
        apply(mk(1, {18'h0, 18'h0, x, 18'h0, t},  5'b00101, 1, 5'b00001, 1, t,     5'b00001, 0), "worm_tail");
        apply(mk(1, {18'h0, 18'h0, x, 18'h0, 18'h0},  5'b00100, 1, 5'b00000, 0, 18'h0, 5'b00000, 1), "worm_gap");
        apply(mk(1, {18'h0, 18'h0, x, 18'h0, 18'h0},  5'b00100, 1, 5'b00100, 1, x,     5'b00100, 1), "p2_head");
        apply(mk(1, {18'h0, 18'h0, x, 18'h0, 18'h0},  5'b00000, 1, 5'b00100, 0, 18'h0, 5'b00100, 1), "p2_drop");
        apply(mk(1, {18'h0, 18'h0, xt, 18'h0, 18'h0}, 5'b00100, 1, 5'b00100, 1, xt,    5'b00100, 1), "p2_tail");
        apply(mk(1, {18'h0, 18'h0, xt, 18'h0, 18'h0}, 5'b00000, 1, 5'b00000, 0, 18'h0, 5'b00000, 2), "p2_done");

        // Reset in the middle of a port-1 packet, then ports 1 and 4 compete.
        p1h = 18'h11111; p1b = 18'h01112; p1h2 = 18'h11113; p4h = 18'h14444;
        apply(mk(1, {18'h0, 18'h0, 18'h0, p1h, 18'h0},  5'b00010, 1, 5'b00000, 0, 18'h0, 5'b00000, 2), "mr_arb");
        apply(mk(1, {18'h0, 18'h0, 18'h0, p1h, 18'h0},  5'b00010, 1, 5'b00010, 1, p1h,   5'b00010, 2), "mr_head");
        apply(mk(0, {18'h0, 18'h0, 18'h0, p1b, 18'h0},  5'b00010, 1, 5'b00000, 0, 18'h0, 5'b00000, 0), "mr_reset");
        apply(mk(1, {p4h, 18'h0, 18'h0, p1h2, 18'h0},   5'b10010, 1, 5'b00000, 0, 18'h0, 5'b00000, 0), "mr_rearb");
        apply(mk(1, {p4h, 18'h0, 18'h0, p1h2, 18'h0},   5'b10010, 1, 5'b00010, 1, p1h2,  5'b00010, 0), "mr_grant1");

        // Random traffic: each port streams packets of 1..4 flits; model tracks ownership.
        @(negedge clk); rst = 1'b0; bus.in_valid = '0;
        @(negedge clk); rst = 1'b1;
        owner = -1; ptr = NI - 1; cnt = 0;
        for (int p = 0; p < NI; p++) begin
            left[p] = $urandom_range(0, 3);
            pf[p]   = {(left[p] == 0) ? 2'b11 : 2'b01, 16'($urandom)};
        end
        for (int c = 0; c < 3000; c++) begin
            logic [NI-1:0] vld, e_grant, e_rdy;
            logic ordy, e_ov;
            int nxt;
            for (int p = 0; p < NI; p++) begin
                vld[p] = ($urandom_range(0, 3) != 0);
                bus.in_flit[p*FW +: FW] = pf[p];
            end
            ordy = ($urandom_range(0, 9) < 7);
            bus.in_valid = vld; bus.out_ready = ordy;
            #1;
            e_grant = (owner >= 0) ? 5'(1 << owner) : 5'b0;
            e_ov    = (owner >= 0) && vld[owner];
            e_rdy   = (owner >= 0 && ordy) ? 5'(1 << owner) : 5'b0;
            check("rnd grant",     32'(grant),         32'(e_grant));
            check("rnd out_valid", 32'(bus.out_valid), 32'(e_ov));
            check("rnd in_ready",  32'(bus.in_ready),  32'(e_rdy));
            check("rnd pkt_cnt",   32'(pkt_cnt),       32'(cnt));
            if (e_ov) check("rnd out_flit", 32'(bus.out_flit), 32'(pf[owner]));
            nxt = owner;
            if (owner < 0) begin
                for (int k = 1; k <= NI; k++) begin
                    int idx;
                    idx = (ptr + k) % NI;
                    if (nxt < 0 && vld[idx] && pf[idx][FW-2]) nxt = idx;
                end
            end else if (vld[owner] && ordy) begin
                $display("xfer cyc=%0d port=%0d flit=%h cnt=%0d", c, owner, pf[owner], cnt);
                if (pf[owner][FW-1]) begin
                    cnt = (cnt + 1) & 16'hffff;
                    ptr = owner;
                    nxt = -1;
                end
                if (left[owner] == 0) begin
                    left[owner] = $urandom_range(0, 3);
                    pf[owner]   = {(left[owner] == 0) ? 2'b11 : 2'b01, 16'($urandom)};
                end else begin
                    left[owner] = left[owner] - 1;
                    pf[owner]   = {(left[owner] == 0) ? 2'b10 : 2'b00, 16'($urandom)};
                end
            end
            owner = nxt;
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/router_out_arb.md
ROUTER_OUT_ARB -- requirements
Module: router_out_arb

Interface
REQ-001 SHALL have parameter FLIT_W, default 18, flit width in bits.
REQ-002 SHALL have parameter NUM_IN, default 5, number of input ports; index 0=W, 1=E, 2=N, 3=S, 4=L.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_flit  input  NUM_IN*FLIT_W  packed input flits; port i occupies bits [i*FLIT_W +: FLIT_W].
REQ-006 SHALL have port in_valid  input  NUM_IN  port i presents a flit routed to this output.
REQ-007 SHALL have port in_ready  output  NUM_IN  flit on port i accepted this cycle when in_valid[i]&in_ready[i].
REQ-008 SHALL have port out_flit  output  FLIT_W  flit forwarded to the output link.
REQ-009 SHALL have port out_valid  output  1  out_flit valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts out_flit.
REQ-011 SHALL have port grant  output  NUM_IN  one-hot current owner; all-zero when idle.
REQ-012 SHALL have port busy  output  1  output port locked to a packet.
REQ-013 SHALL have port pkt_cnt  output  16  completed-packet count, wraps 0xFFFF->0.

Function
REQ-014 SHALL decode flit type from bits [FLIT_W-1:FLIT_W-2]: 00 body, 01 head, 10 tail, 11 single (head+tail).
REQ-015 SHALL implement two states: IDLE and LOCKED.
REQ-016 In IDLE, SHALL treat port i as requester only if in_valid[i] and its flit type is head or single; body/tail flits SHALL be ignored.
REQ-017 In IDLE, SHALL drive out_valid=0, in_ready=0, grant=0, busy=0.
REQ-018 In IDLE with >=1 requester, SHALL select the first requester searching from index ptr+1 upward, wrapping at NUM_IN-1 to 0, and register it as owner; state SHALL be LOCKED next cycle (one-cycle arbitration latency).
REQ-019 In LOCKED, SHALL drive grant=one-hot owner, busy=1, out_flit=in_flit[owner], out_valid=in_valid[owner], in_ready[owner]=out_ready, in_ready of all other ports 0 (combinational path).
REQ-020 A transfer SHALL occur only on out_valid&out_ready; out_flit SHALL be the unmodified owner flit.
REQ-021 On a transfer of a tail or single flit, SHALL return to IDLE next cycle, set ptr<=owner, increment pkt_cnt.
REQ-022 Flits of a packet SHALL never interleave with other ports' flits; ownership SHALL persist until the tail/single transfer regardless of other requests.
REQ-023 A head-type flit from the owner while LOCKED SHALL be forwarded as data and SHALL NOT change ownership.
REQ-024 With out_ready=0, SHALL hold owner and state; no input SHALL see in_ready=1.
REQ-025 Minimum spacing between consecutive packets SHALL be one idle cycle (tail at t, IDLE at t+1, next owner LOCKED at t+2).
REQ-026 Owner dropping in_valid mid-packet SHALL keep LOCKED with out_valid=0 until it resumes.

Reset
REQ-027 On rst=0, SHALL asynchronously force state IDLE, owner none, ptr=NUM_IN-1 (port 0 highest priority next), pkt_cnt=0, grant=0, busy=0, out_valid=0, in_ready=0.
REQ-028 Reset mid-packet SHALL abandon the packet with no further flits forwarded; first arbitration after release SHALL follow REQ-027 priority.
REQ-029 out_flit value during reset/IDLE is don't-care; benches SHALL check it only when out_valid=1.

Verification
REQ-030 Single flit: in_valid=5'b01000, S flit 18'h3a349, out_ready=1 -> next cycle grant=5'b01000, out_valid=1, out_flit=18'h3a349 for one cycle; then IDLE, pkt_cnt=1.
REQ-031 Round-robin: all five ports present single flits continuously, out_ready=1 -> grants in order 0,1,2,3,4,0 each two cycles apart; pkt_cnt=5 after fifth transfer.
REQ-032 Wormhole: port 0 head, body, body, tail while port 2 holds a head -> out_flit sequence is port 0's four flits, grant=5'b00100 only after port 0 tail accepted, no interleaving.
REQ-033 Backpressure: out_ready=0 for 3 cycles mid-packet -> out_flit stable, in_ready=0 on all ports, grant unchanged; resumes with no flit lost or duplicated.
REQ-034 Reset mid-packet: rst=0 during port 1 body flit -> grant=0, busy=0, out_valid=0 immediately; after release with ports 1 and 4 heads, port 1 granted first.
REQ-035 Idle body: body flit 18'h0a349 on port 4 in IDLE -> no grant, in_ready=0, state stays IDLE.
